// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions for the encryption core.
//   SBOX_TABLE / sbox() : forward S-box, byte 0x00 in the top byte of the table
//   xtime()             : multiply-by-x in GF(2^8) mod x^8+x^4+x^3+x+1
//   state_t             : 16-byte state; FIPS-197 byte n sits at packed index 15-n
//   fsm_t               : controller states
//   AES_NR              : round count for AES-128
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [15:0][7:0] state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_TABLE[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encryption round.
//   state_in  [127:0] : round input state (byte 0 in bits [127:120])
//   round_key [127:0] : key XORed in at the end of the round
//   final_rnd         : 1 skips MixColumns (last round)
//   state_out [127:0] : SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_rnd,
    output logic [127:0] state_out
);

    state_t w_in;
    state_t w_sb;
    state_t w_sr;
    state_t w_mc;

    assign w_in = state_in;

    // Byte (row r, column c) is FIPS-197 byte 4c+r, i.e. packed index 15-(4c+r).
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        // NOTE: every variable gets a value before any branch or loop so no latch can be inferred.
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        a0   = '0;
        a1   = '0;
        a2   = '0;
        a3   = '0;

        for (int n = 0; n < 16; n++) begin
            w_sb[n] = sbox(w_in[n]);
        end

        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[15 - (4 * c + r)] = w_sb[15 - (4 * ((c + r) % 4) + r)];
            end
        end

        // Column times the circulant {02,03,01,01}; 03*a is xtime(a)^a.
        for (int c = 0; c < 4; c++) begin
            a0 = w_sr[15 - 4 * c];
            a1 = w_sr[14 - 4 * c];
            a2 = w_sr[13 - 4 * c];
            a3 = w_sr[12 - 4 * c];
            w_mc[15 - 4 * c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            w_mc[14 - 4 * c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            w_mc[13 - 4 * c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            w_mc[12 - 4 * c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    assign state_out = (final_rnd ? w_sr : w_mc) ^ round_key;

endmodule

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryption, one round per clock.
//   HCLK, n_rst            : clock, async active-low reset
//   start, keys_ready      : load request, accepted in IDLE only when keys are valid
//   plaintext   [127:0]    : block sampled on the load edge
//   keyword     [127:0]    : round-0 key (not captured; must stay stable while busy)
//   subkey0..9  [127:0]    : round keys 1..10 (not captured)
//   busy                   : block in flight
//   done                   : one-cycle pulse, ciphertext valid from here on
//   ciphertext  [127:0]    : result, held until the next done
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         HCLK,
    input  logic         n_rst,
    input  logic         start,
    input  logic         keys_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] keyword,
    input  logic [127:0] subkey0,
    input  logic [127:0] subkey1,
    input  logic [127:0] subkey2,
    input  logic [127:0] subkey3,
    input  logic [127:0] subkey4,
    input  logic [127:0] subkey5,
    input  logic [127:0] subkey6,
    input  logic [127:0] subkey7,
    input  logic [127:0] subkey8,
    input  logic [127:0] subkey9,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    fsm_t         r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_st;
    logic         r_busy;
    logic         r_done;
    logic [127:0] r_ct;

    logic [127:0] w_rkey;
    logic [127:0] w_round;
    logic         w_final;

    // Round rnd uses subkey[rnd-1].
    always_comb begin
        case (r_rnd)
            4'd1:    w_rkey = subkey0;
            4'd2:    w_rkey = subkey1;
            4'd3:    w_rkey = subkey2;
            4'd4:    w_rkey = subkey3;
            4'd5:    w_rkey = subkey4;
            4'd6:    w_rkey = subkey5;
            4'd7:    w_rkey = subkey6;
            4'd8:    w_rkey = subkey7;
            4'd9:    w_rkey = subkey8;
            4'd10:   w_rkey = subkey9;
            default: w_rkey = '0;
        endcase
    end

    assign w_final = (r_rnd == 4'(NR));

    aes_round u_round (
        .state_in  (r_st),
        .round_key (w_rkey),
        .final_rnd (w_final),
        .state_out (w_round)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_rnd   <= '0;
            r_st    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ct    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && keys_ready) begin
                        r_st    <= plaintext ^ keyword;
                        r_rnd   <= 4'd1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_final) begin
                        r_ct    <= w_round;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_rnd   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_st  <= w_round;
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ciphertext = r_ct;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb_aes_encrypt_core: scoreboard bench for aes_encrypt_core.
// The reference model derives the S-box from GF(2^8) inverses and the affine map,
// expands keys itself, and encrypts byte-wise. The driver pushes the expected
// ciphertext and accept cycle; a monitor pops on every done pulse.
module tb_aes_encrypt_core;

    logic         HCLK;
    logic         n_rst;
    logic         start;
    logic         keys_ready;
    logic [127:0] plaintext;
    logic [127:0] keyword;
    logic [127:0] sk [10];
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    aes_encrypt_core dut (
        .HCLK       (HCLK),
        .n_rst      (n_rst),
        .start      (start),
        .keys_ready (keys_ready),
        .plaintext  (plaintext),
        .keyword    (keyword),
        .subkey0    (sk[0]),
        .subkey1    (sk[1]),
        .subkey2    (sk[2]),
        .subkey3    (sk[3]),
        .subkey4    (sk[4]),
        .subkey5    (sk[5]),
        .subkey6    (sk[6]),
        .subkey7    (sk[7]),
        .subkey8    (sk[8]),
        .subkey9    (sk[9]),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [127:0] ct;
        int           acc;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] key_sched(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        return {w[4 * n], w[4 * n + 1], w[4 * n + 2], w[4 * n + 3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] rk;
        logic [127:0] res;
        rk = key_sched(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[127 - 8 * i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4 * c] = t[row + 4 * ((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4 * c + k];
                    s[4 * c + 0] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4 * c + 1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                    s[4 * c + 2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                    s[4 * c + 3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                end
            end
            rk = key_sched(key, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8 * i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- driver helpers ----------------
    logic [127:0] cur_key;

    task automatic load_keys(input logic [127:0] key);
        cur_key = key;
        keyword = key;
        for (int i = 0; i < 10; i++) sk[i] = key_sched(key, i + 1);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic issue(input logic [127:0] pt);
        exp_t e;
        @(negedge HCLK);
        plaintext  = pt;
        start      = 1'b1;
        keys_ready = 1'b1;
        @(posedge HCLK);
        #1;
        e.ct  = ref_encrypt(cur_key, pt);
        e.acc = cyc;
        exp_q.push_back(e);
        start = 1'b0;
        check("busy_after_load", 128'(busy), 128'(1));
    endtask

    // ---------------- monitor ----------------
    logic prev_done = 1'b0;

    always @(negedge HCLK) begin
        if (done) begin
            check("done_width", 128'(prev_done), 128'(0));
            check("busy_in_done", 128'(busy), 128'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_done", 128'(done), 128'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ciphertext", ciphertext, e.ct);
                check("latency", 128'(cyc - e.acc), 128'(10));
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_rst      = 1'b0;
        start      = 1'b0;
        keys_ready = 1'b0;
        plaintext  = '0;
        keyword    = '0;
        for (int i = 0; i < 10; i++) sk[i] = '0;
        build_sbox();
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_ct", ciphertext, 128'(0));
        @(negedge HCLK);
        n_rst = 1'b1;

        // FIPS-197 C.1: model sanity, then DUT
        load_keys(C1_KEY);
        check("model_subkey0", sk[0], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("model_subkey9", sk[9], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_c1", ref_encrypt(C1_KEY, C1_PT), C1_CT);
        issue(C1_PT);
        wait_edges(10);

        // Appendix B, plaintext disturbed after the load edge
        load_keys(B_KEY);
        check("model_b", ref_encrypt(B_KEY, B_PT), B_CT);
        issue(B_PT);
        plaintext = $urandom();
        wait_edges(10);
        wait_edges(5);
        check("ct_hold_idle", ciphertext, B_CT);

        // Gating by keys_ready
        @(negedge HCLK);
        start      = 1'b1;
        keys_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_edges(1);
            check("gated_busy", 128'(busy), 128'(0));
        end
        start      = 1'b0;
        keys_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_edges(1);
            check("idle_busy", 128'(busy), 128'(0));
        end

        // Back-to-back with start held high
        load_keys(C1_KEY);
        @(negedge HCLK);
        plaintext  = C1_PT;
        start      = 1'b1;
        keys_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            @(posedge HCLK);
            #1;
            e.ct  = C1_CT;
            e.acc = cyc;
            exp_q.push_back(e);
            check("b2b_busy", 128'(busy), 128'(1));
            if (k == 2) start = 1'b0;
            wait_edges(10);
        end

        // Randomized blocks with mid-block noise on start/keys_ready/plaintext
        for (int it = 0; it < 8; it++) begin
            load_keys({$urandom(), $urandom(), $urandom(), $urandom()});
            issue({$urandom(), $urandom(), $urandom(), $urandom()});
            wait_edges(2);
            keys_ready = 1'b0;
            wait_edges(2);
            keys_ready = 1'b1;
            start      = 1'b1;
            plaintext  = {$urandom(), $urandom(), $urandom(), $urandom()};
            wait_edges(1);
            start = 1'b0;
            wait_edges(5);
            wait_edges(int'($urandom_range(0, 3)));
        end

        // Reset five cycles into a block
        load_keys(C1_KEY);
        issue(C1_PT);
        wait_edges(5);
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_ct", ciphertext, 128'(0));
        exp_q.delete();
        @(negedge HCLK);
        n_rst = 1'b1;
        issue(C1_PT);
        wait_edges(10);
        wait_edges(3);
        check("ct_after_reset", ciphertext, C1_CT);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge HCLK);
        check("drain", 128'(exp_q.size()), 128'(0));
        wait_edges(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
